// File: rtl/cache_nwsa_ctrl.sv
// rtl/cache_nwsa_ctrl.sv - N-way set-associative write-back/write-allocate cache controller
module cache_nwsa_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int WAYS      = 2,
  parameter int SET_BITS  = 4,
  parameter int WORD_BITS = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr_cpu,
  input  logic [DATA_W-1:0] wdata_cpu,
  input  logic              rd_cpu,
  input  logic              wr_cpu,
  output logic [DATA_W-1:0] rdata_cpu,
  output logic              stall_cpu,
  output logic [ADDR_W-1:0] addr_mem,
  output logic [DATA_W-1:0] wdata_mem,
  input  logic [DATA_W-1:0] rdata_mem,
  output logic              rd_mem,
  output logic              wr_mem,
  input  logic              ready_mem,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << WORD_BITS;
  localparam int TAG_W = ADDR_W - SET_BITS - WORD_BITS;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:0]    req_addr_q;
  logic [DATA_W-1:0]    req_wdata_q;
  logic                 req_wr_q;
  logic                 first_q;     // set until the first lookup of a request; refill re-lookups are not counted
  logic [WAY_W-1:0]     victim_q;
  logic [WORD_BITS-1:0] beat_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [CNT_W-1:0]     hit_q, miss_q;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS][WORDS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];

  logic [WORD_BITS-1:0] req_word;
  logic [SET_BITS-1:0]  req_set;
  logic [TAG_W-1:0]     req_tag;
  assign req_word = req_addr_q[WORD_BITS-1:0];
  assign req_set  = req_addr_q[WORD_BITS+SET_BITS-1:WORD_BITS];
  assign req_tag  = req_addr_q[ADDR_W-1:WORD_BITS+SET_BITS];

  logic             hit, has_free;
  logic [WAY_W-1:0] hit_way, free_way, lru_way, victim;
  logic             last_beat;
  assign last_beat = ready_mem && (beat_q == LAST_BEAT);

  // Tag match and lowest-index free way; descending scan so the lowest index wins
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    has_free = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_set][w]) begin
        has_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  assign victim = has_free ? free_way : lru_way;

  generate
    if (WAYS > 1) begin : g_age
      logic [WAY_W-1:0] age_q [SETS][WAYS];

      // The way holding the oldest age is the replacement candidate
      always_comb begin
        lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[req_set][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
        end
      end

      // True-LRU aging: touched way becomes youngest, younger ways shift up by one
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
          end
        end else if (state_q == S_LOOKUP && hit) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == hit_way) age_q[req_set][w] <= '0;
            else if (age_q[req_set][w] < age_q[req_set][hit_way])
              age_q[req_set][w] <= age_q[req_set][w] + 1'b1;
          end
        end
      end
    end else begin : g_no_age
      assign lru_way = '0;
    end
  endgenerate

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (rd_cpu || wr_cpu) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (hit) state_d = S_IDLE;
        else if (valid_q[req_set][victim] && dirty_q[req_set][victim]) state_d = S_WRITEBACK;
        else state_d = S_REFILL;
      end
      S_WRITEBACK: if (last_beat) state_d = S_REFILL;
      S_REFILL:    if (last_beat) state_d = S_LOOKUP;
      default:     state_d = S_IDLE;
    endcase
  end

  // Memory-side outputs decode straight from state so reset drops the strobes at once
  always_comb begin
    addr_mem  = '0;
    wdata_mem = '0;
    rd_mem    = 1'b0;
    wr_mem    = 1'b0;
    if (state_q == S_WRITEBACK) begin
      addr_mem  = {tag_q[req_set][victim_q], req_set, beat_q};
      wdata_mem = data_q[req_set][victim_q][beat_q];
      wr_mem    = 1'b1;
    end else if (state_q == S_REFILL) begin
      addr_mem = {req_tag, req_set, beat_q};
      rd_mem   = 1'b1;
    end
  end

  assign stall_cpu  = (state_q != S_IDLE);
  assign rdata_cpu  = rdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // Control state, request latch, line status bits and counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wr_q    <= 1'b0;
      first_q     <= 1'b0;
      victim_q    <= '0;
      beat_q      <= '0;
      rdata_q     <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (rd_cpu || wr_cpu) begin
            req_addr_q  <= addr_cpu;
            req_wdata_q <= wdata_cpu;
            req_wr_q    <= !rd_cpu;
            first_q     <= 1'b1;
          end
        end
        S_LOOKUP: begin
          first_q <= 1'b0;
          if (hit) begin
            if (req_wr_q) dirty_q[req_set][hit_way] <= 1'b1;
            else rdata_q <= data_q[req_set][hit_way][req_word];
            if (first_q && (hit_q != '1)) hit_q <= hit_q + 1'b1;
          end else begin
            if (miss_q != '1) miss_q <= miss_q + 1'b1;
            victim_q <= victim;
            beat_q   <= '0;
          end
        end
        S_WRITEBACK: begin
          if (ready_mem) beat_q <= beat_q + 1'b1;
          if (last_beat) dirty_q[req_set][victim_q] <= 1'b0;
        end
        S_REFILL: begin
          if (ready_mem) beat_q <= beat_q + 1'b1;
          if (last_beat) begin
            valid_q[req_set][victim_q] <= 1'b1;
            dirty_q[req_set][victim_q] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays are not reset; they are only meaningful behind a valid bit
  always_ff @(posedge clock) begin
    if (state_q == S_LOOKUP && hit && req_wr_q)
      data_q[req_set][hit_way][req_word] <= req_wdata_q;
    if (state_q == S_REFILL && ready_mem) begin
      data_q[req_set][victim_q][beat_q] <= rdata_mem;
      if (beat_q == LAST_BEAT) tag_q[req_set][victim_q] <= req_tag;
    end
  end
endmodule

// File: tb/tb_cache_nwsa_ctrl.sv
// tb/tb_cache_nwsa_ctrl.sv - self-checking bench for cache_nwsa_ctrl (4-way, 4-bit counters)
module tb_cache_nwsa_ctrl;
  localparam int WAYS  = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] addr_cpu = '0;
  logic [7:0]  wdata_cpu = '0;
  logic        rd_cpu = 1'b0, wr_cpu = 1'b0;
  logic [7:0]  rdata_cpu;
  logic        stall_cpu;
  logic [15:0] addr_mem;
  logic [7:0]  wdata_mem, rdata_mem;
  logic        rd_mem, wr_mem;
  logic        ready_mem = 1'b1;
  logic [CNT_W-1:0] hit_count, miss_count;

  always #5 clock = ~clock;

  cache_nwsa_ctrl #(.ADDR_W(16), .DATA_W(8), .WAYS(WAYS), .SET_BITS(4), .WORD_BITS(2), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .addr_cpu(addr_cpu), .wdata_cpu(wdata_cpu),
    .rd_cpu(rd_cpu), .wr_cpu(wr_cpu), .rdata_cpu(rdata_cpu), .stall_cpu(stall_cpu),
    .addr_mem(addr_mem), .wdata_mem(wdata_mem), .rdata_mem(rdata_mem),
    .rd_mem(rd_mem), .wr_mem(wr_mem), .ready_mem(ready_mem),
    .hit_count(hit_count), .miss_count(miss_count));

  // Main memory and its ready behaviour
  logic [7:0] mem [0:65535];
  assign rdata_mem = mem[addr_mem];
  int ready_mode = 0;
  int wait_cnt = 0;

  always @(negedge clock) begin
    if (ready_mode == 0) ready_mem = 1'b1;
    else if (ready_mode == 1) ready_mem = 1'($urandom_range(0, 1));
    else if (rd_mem || wr_mem) begin
      if (wait_cnt == 3) begin ready_mem = 1'b1; wait_cnt = 0; end
      else begin ready_mem = 1'b0; wait_cnt++; end
    end else begin
      ready_mem = 1'b0; wait_cnt = 0;
    end
  end

  // Beat recorder and hold-stability tracker
  logic [15:0] rd_addrs[$], wr_addrs[$];
  logic [7:0]  wr_datas[$];
  int held_cycles = 0, hold_breaks = 0;
  bit hold_pend = 0;
  logic [15:0] hold_addr;
  logic [7:0]  hold_wd;
  logic        hold_rd, hold_wr;

  always @(posedge clock) begin
    if (hold_pend && !(rd_mem === hold_rd && wr_mem === hold_wr && addr_mem === hold_addr && wdata_mem === hold_wd))
      hold_breaks++;
    hold_pend = (rd_mem || wr_mem) && !ready_mem;
    if (hold_pend) begin
      held_cycles++;
      hold_addr = addr_mem; hold_wd = wdata_mem; hold_rd = rd_mem; hold_wr = wr_mem;
    end
    if (rd_mem && ready_mem) rd_addrs.push_back(addr_mem);
    if (wr_mem && ready_mem) begin
      wr_addrs.push_back(addr_mem);
      wr_datas.push_back(wdata_mem);
      mem[addr_mem] = wdata_mem;
    end
  end

  // Reference model: per-set recency list of tags, dirty flag per line, CPU-visible value per address
  int         lru_q [16][$];
  bit         m_dirty [0:16383];
  logic [7:0] m_val [0:65535];
  int         m_hits = 0, m_miss = 0;
  int         n_pass = 0, n_total = 0;

  task automatic model_reset();
    for (int s = 0; s < 16; s++) lru_q[s].delete();
    for (int l = 0; l < 16384; l++) m_dirty[l] = 1'b0;
    for (int a = 0; a < 65536; a++) m_val[a] = mem[a];
    m_hits = 0; m_miss = 0;
  endtask

  task automatic model_access(input bit wr, input logic [15:0] a, input logic [7:0] d,
                              output bit hit, output bit wb, output int vline);
    int line, set, tag, idx, vt;
    line = int'(a) >> 2; set = line % 16; tag = line / 16; idx = -1;
    wb = 1'b0; vline = -1;
    for (int i = 0; i < lru_q[set].size(); i++) if (lru_q[set][i] == tag) idx = i;
    if (idx >= 0) begin
      hit = 1'b1;
      lru_q[set].delete(idx);
      if (m_hits < CMAX) m_hits++;
    end else begin
      hit = 1'b0;
      if (m_miss < CMAX) m_miss++;
      if (lru_q[set].size() == WAYS) begin
        vt = lru_q[set].pop_back();
        vline = vt * 16 + set;
        wb = m_dirty[vline];
        m_dirty[vline] = 1'b0;
      end
    end
    lru_q[set].push_front(tag);
    if (wr) begin m_val[a] = d; m_dirty[line] = 1'b1; end
  endtask

  task automatic do_access(input bit wr, input logic [15:0] a, input logic [7:0] d,
                           output int cycles, output bit tmo);
    rd_addrs.delete(); wr_addrs.delete(); wr_datas.delete();
    @(negedge clock);
    rd_cpu = !wr; wr_cpu = wr; addr_cpu = a; wdata_cpu = d;
    @(posedge clock);
    cycles = 0; tmo = 1'b0;
    forever begin
      @(negedge clock);
      if (!stall_cpu) break;
      cycles++;
      if (cycles > 400) begin tmo = 1'b1; break; end
    end
    rd_cpu = 1'b0; wr_cpu = 1'b0;
  endtask

  task automatic run_op(input bit wr, input logic [15:0] a, input logic [7:0] d,
                        output int cyc, output bit hit, output bit wb, output int vline);
    bit tmo;
    do_access(wr, a, d, cyc, tmo);
    n_total++;
    if (tmo) $display("FAIL access_timeout addr=%h: stall still high after %0d cycles, required completion", a, cyc);
    else n_pass++;
    model_access(wr, a, d, hit, wb, vline);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_total++; if ({rdata_cpu, stall_cpu, rd_mem, wr_mem} !== 11'h0) $display("FAIL reset_cpu_side: got %h required 0", {rdata_cpu, stall_cpu, rd_mem, wr_mem}); else n_pass++;
    n_total++; if ({addr_mem, wdata_mem} !== 24'h0) $display("FAIL reset_mem_bus: got %h required 0", {addr_mem, wdata_mem}); else n_pass++;
    n_total++; if ({hit_count, miss_count} !== '0) $display("FAIL reset_counters: got %h required 0", {hit_count, miss_count}); else n_pass++;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_miss_refill();
    int cyc, vl; bit h, wb;
    ready_mode = 0;
    run_op(1'b0, 16'h0093, 8'h00, cyc, h, wb, vl);
    n_total++; if (cyc !== 6) $display("FAIL clean_miss_stall: got %0d required 6", cyc); else n_pass++;
    n_total++; if (rd_addrs.size() !== 4) $display("FAIL clean_miss_beats: got %0d required 4", rd_addrs.size()); else n_pass++;
    for (int k = 0; k < 4 && k < rd_addrs.size(); k++) begin
      n_total++; if (rd_addrs[k] !== 16'h0090 + 16'(k)) $display("FAIL refill_addr%0d: got %h required %h", k, rd_addrs[k], 16'h0090 + 16'(k)); else n_pass++;
    end
    n_total++; if (rdata_cpu !== 8'hA3) $display("FAIL miss_rdata: got %h required a3", rdata_cpu); else n_pass++;
    n_total++; if (miss_count !== 4'd1) $display("FAIL miss_count_1: got %0d required 1", miss_count); else n_pass++;
  endtask

  task automatic test_write_hit();
    int cyc, vl; bit h, wb;
    run_op(1'b1, 16'h0093, 8'h17, cyc, h, wb, vl);
    n_total++; if (cyc !== 1 || rd_addrs.size() + wr_addrs.size() !== 0) $display("FAIL write_hit: stall %0d beats %0d, required 1 and 0", cyc, rd_addrs.size() + wr_addrs.size()); else n_pass++;
    run_op(1'b0, 16'h0093, 8'h00, cyc, h, wb, vl);
    n_total++; if (cyc !== 1 || rd_addrs.size() + wr_addrs.size() !== 0) $display("FAIL read_hit: stall %0d beats %0d, required 1 and 0", cyc, rd_addrs.size() + wr_addrs.size()); else n_pass++;
    n_total++; if (rdata_cpu !== 8'h17) $display("FAIL read_after_write: got %h required 17", rdata_cpu); else n_pass++;
    n_total++; if (hit_count !== 4'd2) $display("FAIL hit_count_2: got %0d required 2", hit_count); else n_pass++;
  endtask

  task automatic test_dirty_evict();
    int cyc, vl; bit h, wb;
    logic [7:0] exp_wd [4];
    exp_wd[0] = 8'hA0; exp_wd[1] = 8'hA1; exp_wd[2] = 8'hA2; exp_wd[3] = 8'h17;
    for (int t = 1; t <= 3; t++) begin
      run_op(1'b0, 16'(t << 10) | 16'h0093, 8'h00, cyc, h, wb, vl);
      n_total++; if (cyc !== 6 || wr_addrs.size() !== 0) $display("FAIL fill_way%0d: stall %0d wb beats %0d, required 6 and 0", t, cyc, wr_addrs.size()); else n_pass++;
    end
    run_op(1'b0, 16'h1093, 8'h00, cyc, h, wb, vl);
    n_total++; if (cyc !== 10) $display("FAIL dirty_miss_stall: got %0d required 10", cyc); else n_pass++;
    n_total++; if (wr_addrs.size() !== 4 || rd_addrs.size() !== 4) $display("FAIL dirty_miss_beats: wr %0d rd %0d required 4 and 4", wr_addrs.size(), rd_addrs.size()); else n_pass++;
    for (int k = 0; k < 4 && k < wr_addrs.size() && k < rd_addrs.size(); k++) begin
      n_total++; if (wr_addrs[k] !== 16'h0090 + 16'(k) || wr_datas[k] !== exp_wd[k]) $display("FAIL writeback%0d: got %h/%h required %h/%h", k, wr_addrs[k], wr_datas[k], 16'h0090 + 16'(k), exp_wd[k]); else n_pass++;
      n_total++; if (rd_addrs[k] !== 16'h1090 + 16'(k)) $display("FAIL evict_refill%0d: got %h required %h", k, rd_addrs[k], 16'h1090 + 16'(k)); else n_pass++;
    end
    n_total++; if (miss_count !== 4'd5) $display("FAIL miss_count_5: got %0d required 5", miss_count); else n_pass++;
  endtask

  task automatic test_slow_ready();
    int cyc, vl; bit h, wb;
    logic [7:0] expv;
    ready_mode = 2; held_cycles = 0; hold_breaks = 0;
    run_op(1'b0, 16'h0041, 8'h00, cyc, h, wb, vl);
    n_total++; if (cyc !== 18) $display("FAIL slow_stall: got %0d required 18", cyc); else n_pass++;
    n_total++; if (held_cycles !== 12 || hold_breaks !== 0) $display("FAIL slow_hold: held %0d breaks %0d required 12 and 0", held_cycles, hold_breaks); else n_pass++;
    n_total++; if (rd_addrs.size() !== 4) $display("FAIL slow_beats: got %0d required 4", rd_addrs.size()); else n_pass++;
    n_total++; if (rdata_cpu !== 8'hA1) $display("FAIL slow_rdata: got %h required a1", rdata_cpu); else n_pass++;
    for (int w = 0; w < 4; w++) begin
      run_op(1'b0, 16'h0040 + 16'(w), 8'h00, cyc, h, wb, vl);
      expv = 8'hA0 + 8'(w);
      n_total++; if (rdata_cpu !== expv || cyc !== 1) $display("FAIL slow_word%0d: got %h stall %0d required %h stall 1", w, rdata_cpu, cyc, expv); else n_pass++;
    end
    ready_mode = 0;
  endtask

  task automatic test_reset_midburst();
    int cyc, vl; bit h, wb;
    ready_mode = 0;
    @(negedge clock);
    rd_cpu = 1'b1; addr_cpu = 16'h0082;
    repeat (3) @(posedge clock);
    @(negedge clock);
    rd_cpu = 1'b0;
    n_total++; if (rd_mem !== 1'b1 || addr_mem !== 16'h0081) $display("FAIL second_beat: rd %b addr %h required 1 0081", rd_mem, addr_mem); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++; if (rd_mem !== 1'b0 || stall_cpu !== 1'b0 || addr_mem !== 16'h0) $display("FAIL async_reset: rd %b stall %b addr %h required 0 0 0", rd_mem, stall_cpu, addr_mem); else n_pass++;
    n_total++; if (rdata_cpu !== 8'h0 || hit_count !== 4'd0 || miss_count !== 4'd0) $display("FAIL async_reset_regs: %h %0d %0d required 0", rdata_cpu, hit_count, miss_count); else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    run_op(1'b0, 16'h0082, 8'h00, cyc, h, wb, vl);
    n_total++; if (rd_addrs.size() !== 4 || miss_count !== 4'd1) $display("FAIL post_reset_miss: beats %0d misses %0d required 4 and 1", rd_addrs.size(), miss_count); else n_pass++;
    n_total++; if (rdata_cpu !== 8'hA2) $display("FAIL post_reset_rdata: got %h required a2", rdata_cpu); else n_pass++;
  endtask

  task automatic test_lru();
    int cyc, vl; bit h, wb, obs;
    int tags [10] = '{1, 2, 3, 4, 1, 5, 2, 1, 4, 5};
    bit exp_hit [10] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 1};
    for (int i = 0; i < 10; i++) begin
      run_op(1'b0, 16'(tags[i] << 6) | 16'h000C | 16'(tags[i] & 3), 8'h00, cyc, h, wb, vl);
      obs = (rd_addrs.size() == 0);
      n_total++; if (obs !== exp_hit[i] || wr_addrs.size() !== 0) $display("FAIL lru_step%0d tag %0d: hit %b wb %0d required hit %b wb 0", i, tags[i], obs, wr_addrs.size(), exp_hit[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit h, wb; int vl;
    rd_addrs.delete();
    @(negedge clock);
    rd_cpu = 1'b1; addr_cpu = 16'h004D;
    repeat (6) @(negedge clock);
    rd_cpu = 1'b0;
    for (int i = 0; i < 3; i++) model_access(1'b0, 16'h004D, 8'h00, h, wb, vl);
    n_total++; if (hit_count !== 4'(m_hits) || rd_addrs.size() !== 0) $display("FAIL held_request: hits %0d beats %0d required %0d and 0", hit_count, rd_addrs.size(), m_hits); else n_pass++;
    n_total++; if (rdata_cpu !== m_val[16'h004D]) $display("FAIL held_rdata: got %h required %h", rdata_cpu, m_val[16'h004D]); else n_pass++;
  endtask

  task automatic test_random();
    int cyc, vl; bit h, wb, wr;
    logic [15:0] a; logic [7:0] d;
    int sets [3] = '{0, 1, 3};
    ready_mode = 1;
    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 16'(($urandom_range(0, 5) << 6) | (sets[$urandom_range(0, 2)] << 2) | $urandom_range(0, 3));
      d  = 8'($urandom);
      run_op(wr, a, d, cyc, h, wb, vl);
      n_total++; if (rd_addrs.size() !== (h ? 0 : 4) || wr_addrs.size() !== (wb ? 4 : 0)) $display("FAIL rnd%0d_beats addr %h: rd %0d wr %0d required %0d %0d", i, a, rd_addrs.size(), wr_addrs.size(), h ? 0 : 4, wb ? 4 : 0); else n_pass++;
      if (wb) for (int k = 0; k < 4 && k < wr_addrs.size(); k++) begin
        n_total++; if (wr_addrs[k] !== 16'(vl * 4 + k) || wr_datas[k] !== m_val[vl * 4 + k]) $display("FAIL rnd%0d_wb%0d: got %h/%h required %h/%h", i, k, wr_addrs[k], wr_datas[k], 16'(vl * 4 + k), m_val[vl * 4 + k]); else n_pass++;
      end
      if (!wr) begin
        n_total++; if (rdata_cpu !== m_val[a]) $display("FAIL rnd%0d_rdata addr %h: got %h required %h", i, a, rdata_cpu, m_val[a]); else n_pass++;
      end
      n_total++; if (hit_count !== 4'(m_hits) || miss_count !== 4'(m_miss)) $display("FAIL rnd%0d_counters: %0d/%0d required %0d/%0d", i, hit_count, miss_count, m_hits, m_miss); else n_pass++;
    end
    ready_mode = 0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'hA0 + 8'(a & 3);
    test_reset();
    test_miss_refill();
    test_write_hit();
    test_dirty_evict();
    test_slow_ready();
    test_reset_midburst();
    test_lru();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
